hssl_rx_pkt_merger: RTL and testbench
=====================================

Name: hssl_rx_pkt_merger

Overview:
- Sits directly downstream of the HSSL interface receive side.
- Consumes the NUM_CHANNELS per-channel received packet streams and merges them, round-robin, into a single packet stream for the on-FPGA packet router.
- Tags each packet with its source channel, drops packets while the link handshake is incomplete, and keeps saturating packet/drop counters for diagnostics.
- Output side is a 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready.

Parameters:
- PACKET_BITS, 72, width of one packet.
- NUM_CHANNELS, 8, number of input streams (power of 2, 2..8).
- CHAN_BITS, 3, width of channel tag (= log2 NUM_CHANNELS).
- CNT_BITS, 32, width of each diagnostic counter.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- rxpkt_data_in  in  PACKET_BITS x NUM_CHANNELS  per-channel packet data.
- rxpkt_vld_in  in  1 x NUM_CHANNELS  per-channel valid.
- rxpkt_rdy_out  out  1 x NUM_CHANNELS  per-channel ready.
- handshake_complete_in  in  1  link handshake done; when low, inputs are flushed.
- pkt_data_out  out  PACKET_BITS  merged packet data.
- pkt_chan_out  out  CHAN_BITS  source channel of pkt_data_out.
- pkt_vld_out  out  1  merged valid.
- pkt_rdy_in  in  1  downstream ready.
- pkt_cnt_out  out  CNT_BITS  packets delivered downstream (saturating).
- drop_cnt_out  out  CNT_BITS  packets dropped while handshake incomplete (saturating).

Behaviour:
- Reset (reset_n low, async): buffer empty; pkt_vld_out=0; pkt_data_out=0; pkt_chan_out=0; rr pointer=0; both counters=0; rxpkt_rdy_out all 0 while in reset.
- Transfer rule: an input transfer occurs when rxpkt_vld_in[i] && rxpkt_rdy_out[i]. An output transfer occurs when pkt_vld_out && pkt_rdy_in.
- Grant (combinational):
  - g = first i with rxpkt_vld_in[i], searching from rr pointer upward with wrap-around.
  - No grant if no input is valid.
- Merge mode (handshake_complete_in=1):
  - rxpkt_rdy_out[g]=1 only if the registered buffer count < 2; all other readies are 0.
  - At most one input transfer per cycle.
  - Granted packet and its channel index g are written to the buffer tail.
- Flush mode (handshake_complete_in=0):
  - rxpkt_rdy_out[i]=rxpkt_vld_in[i] for all i; every valid input is accepted and discarded.
  - drop_cnt_out += popcount of transfers that cycle, saturating at all-ones.
  - Packets already in the buffer are retained and delivered normally; pkt_vld_out is never withdrawn once asserted.
- rr pointer: after an input transfer in merge mode, pointer <= (g+1) mod NUM_CHANNELS; otherwise unchanged. Flush does not move it.
- Skid buffer (2 entries: head = output register, plus one spare):
  - count in {0,1,2}.
  - pkt_vld_out = (count != 0); pkt_data_out/pkt_chan_out present the head.
  - Head updates only on output transfer or when loading an empty buffer.
  - Latency: input transfer in cycle N gives pkt_vld_out=1 in cycle N+1 if the buffer was empty.
  - Simultaneous push and pop at count=1: head <= new packet, count stays 1.
  - At count=2: no push possible, since all ready=0 in merge mode.
  - Pop at count=2: spare moves to head, count=1.
  - Order preserved (FIFO).
- pkt_cnt_out increments by 1 per output transfer, saturating at all-ones; no wrap.
- rxpkt_rdy_out depends only on registered state, rxpkt_vld_in and handshake_complete_in; never on pkt_rdy_in.
- Reset asserted mid-operation: buffered packets are lost and counters clear immediately (async).

Test Plan:
- Single channel: ch3 sends 0xA1, 0xA2 back-to-back, pkt_rdy_in=1 -> out 0xA1 then 0xA2, chan=3, each 1 cycle after input; pkt_cnt_out=2.
- All 8 channels valid continuously, pointer=0 -> grants ch0,1,...,7,0 in order, one per cycle; pkt_chan_out follows the same sequence; no packet lost or duplicated.
- Backpressure: pkt_rdy_in=0, ch0 and ch5 valid -> 2 packets buffered, all rdy_out=0 on the 3rd cycle, pkt_vld_out held with data stable. Then pkt_rdy_in=1 -> ch0, ch5, then the next packets, in FIFO order.
- Flush: handshake_complete_in=0 with 1 packet buffered, ch1/ch2/ch6 valid for 4 cycles -> drop_cnt_out=12; the buffered packet is still delivered; pkt_cnt_out=1.
- Saturation with CNT_BITS=4: deliver 20 packets -> pkt_cnt_out=15; flush 20 packets -> drop_cnt_out=15.
- Async reset mid-stream with count=2 -> outputs zero within the same cycle; after release, first packet from ch0 passes with latency 1.

Source files
------------

// File: rtl/hssl_rx_pkt_merger_if.sv
// Bundle of the per-channel receive streams, the merged output stream and the
// diagnostic counters of the HSSL receive packet merger.
interface hssl_rx_pkt_merger_if #(
    parameter int PACKET_BITS  = 72,
    parameter int NUM_CHANNELS = 8,
    parameter int CHAN_BITS    = 3,
    parameter int CNT_BITS     = 32
);
    logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0] rxpkt_data_in;
    logic [NUM_CHANNELS-1:0]                  rxpkt_vld_in;
    logic [NUM_CHANNELS-1:0]                  rxpkt_rdy_out;
    logic                                     handshake_complete_in;
    logic [PACKET_BITS-1:0]                   pkt_data_out;
    logic [CHAN_BITS-1:0]                     pkt_chan_out;
    logic                                     pkt_vld_out;
    logic                                     pkt_rdy_in;
    logic [CNT_BITS-1:0]                      pkt_cnt_out;
    logic [CNT_BITS-1:0]                      drop_cnt_out;

    // Environment side: drives the receive streams and the downstream ready.
    modport master (
        output rxpkt_data_in, rxpkt_vld_in, handshake_complete_in, pkt_rdy_in,
        input  rxpkt_rdy_out, pkt_data_out, pkt_chan_out, pkt_vld_out,
               pkt_cnt_out, drop_cnt_out
    );

    // Merger side.
    modport slave (
        input  rxpkt_data_in, rxpkt_vld_in, handshake_complete_in, pkt_rdy_in,
        output rxpkt_rdy_out, pkt_data_out, pkt_chan_out, pkt_vld_out,
               pkt_cnt_out, drop_cnt_out
    );
endinterface

// File: rtl/hssl_rx_pkt_merger.sv
// Round-robin merger of the HSSL per-channel receive streams into one tagged
// packet stream, with a 2-entry output skid buffer and saturating diagnostics.
module hssl_rx_pkt_merger #(
    parameter int PACKET_BITS  = 72,
    parameter int NUM_CHANNELS = 8,
    parameter int CHAN_BITS    = 3,
    parameter int CNT_BITS     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hssl_rx_pkt_merger_if.slave   bus
);

    typedef struct packed {
        logic [CHAN_BITS-1:0]   chan;
        logic [PACKET_BITS-1:0] data;
    } entry_t;

    logic [CHAN_BITS-1:0] rr_q;
    logic [CHAN_BITS-1:0] grant_idx;
    logic [CHAN_BITS-1:0] scan_idx;
    logic                 grant_vld;
    logic [1:0]           count_q;
    entry_t               head_q;
    entry_t               spare_q;
    entry_t               entry_in;
    logic                 push;
    logic                 pop;
    logic [CHAN_BITS:0]   drop_num;
    logic [CNT_BITS-1:0]  pkt_cnt_q;
    logic [CNT_BITS-1:0]  drop_cnt_q;

    function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                    input logic [CHAN_BITS:0]  b);
        logic [CNT_BITS:0] sum;
        sum = {1'b0, a} + (CNT_BITS+1)'(b);
        return sum[CNT_BITS] ? '1 : sum[CNT_BITS-1:0];
    endfunction

    // Scan downward so the last hit is the first valid channel at or after rr_q.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = rr_q;
        scan_idx  = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            scan_idx = rr_q + CHAN_BITS'(k);
            if (bus.rxpkt_vld_in[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign push     = bus.handshake_complete_in && grant_vld && (count_q != 2'd2);
    assign pop      = (count_q != 2'd0) && bus.pkt_rdy_in;
    assign entry_in = {grant_idx, bus.rxpkt_data_in[grant_idx]};

    // Ready is built from registered occupancy only, never from pkt_rdy_in.
    always_comb begin
        bus.rxpkt_rdy_out = '0;
        if (reset_n) begin
            if (!bus.handshake_complete_in)
                bus.rxpkt_rdy_out = bus.rxpkt_vld_in;
            else
                bus.rxpkt_rdy_out[grant_idx] = push;
        end
    end

    always_comb begin
        drop_num = '0;
        if (!bus.handshake_complete_in) begin
            for (int i = 0; i < NUM_CHANNELS; i++)
                drop_num = drop_num + {{CHAN_BITS{1'b0}}, bus.rxpkt_vld_in[i]};
        end
    end

    // NOTE: buffer entries are reset too, because the head drives pkt_data_out/pkt_chan_out directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            spare_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= entry_in;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= entry_in;
                    end else if (push) begin
                        spare_q <= entry_in;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q  <= spare_q;
                        count_q <= 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q       <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push)
                rr_q <= grant_idx + CHAN_BITS'(1);
            if (pop)
                pkt_cnt_q <= sat_add(pkt_cnt_q, (CHAN_BITS+1)'(1));
            if (!bus.handshake_complete_in)
                drop_cnt_q <= sat_add(drop_cnt_q, drop_num);
        end
    end

    assign bus.pkt_vld_out  = (count_q != 2'd0);
    assign bus.pkt_data_out = head_q.data;
    assign bus.pkt_chan_out = head_q.chan;
    assign bus.pkt_cnt_out  = pkt_cnt_q;
    assign bus.drop_cnt_out = drop_cnt_q;

endmodule

// File: tb/tb_hssl_rx_pkt_merger.sv
// Directed and randomized bench for hssl_rx_pkt_merger against a queue-based
// model of the merged stream, run with 4-bit counters to reach saturation.
module tb_hssl_rx_pkt_merger;

    localparam int PB  = 72;
    localparam int NCH = 8;
    localparam int CB  = 3;
    localparam int CNT = 4;
    localparam int CNT_MAX = (1 << CNT) - 1;

    typedef struct {
        int            chan;
        logic [PB-1:0] data;
    } ent_t;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_err    = 0;

    ent_t mq[$];
    int   m_rr, m_pkt, m_drop;

    hssl_rx_pkt_merger_if #(.PACKET_BITS(PB), .NUM_CHANNELS(NCH), .CHAN_BITS(CB), .CNT_BITS(CNT)) bus ();

    hssl_rx_pkt_merger #(.PACKET_BITS(PB), .NUM_CHANNELS(NCH), .CHAN_BITS(CB), .CNT_BITS(CNT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PB-1:0] rnd_pkt();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[PB-1:0];
    endfunction

    task automatic rnd_data();
        for (int i = 0; i < NCH; i++) bus.rxpkt_data_in[i] = rnd_pkt();
    endtask

    // Ready the spec predicts from the current model state and inputs.
    function automatic logic [NCH-1:0] exp_rdy();
        logic [NCH-1:0] r;
        r = '0;
        if (!reset_n) return r;
        if (!bus.handshake_complete_in) return bus.rxpkt_vld_in;
        if (mq.size() >= 2) return r;
        for (int k = 0; k < NCH; k++) begin
            if (bus.rxpkt_vld_in[(m_rr + k) % NCH]) begin
                r[(m_rr + k) % NCH] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle();
        logic [NCH-1:0] er;
        #1;
        er = exp_rdy();
        check("rdy_out", 80'(bus.rxpkt_rdy_out), 80'(er));
        check("vld_out", 80'(bus.pkt_vld_out), 80'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("data_out", 80'(bus.pkt_data_out), 80'(mq[0].data));
            check("chan_out", 80'(bus.pkt_chan_out), 80'(mq[0].chan));
        end
        check("pkt_cnt", 80'(bus.pkt_cnt_out), 80'(m_pkt));
        check("drop_cnt", 80'(bus.drop_cnt_out), 80'(m_drop));
        @(posedge clk);
        if (mq.size() != 0 && bus.pkt_rdy_in) begin
            void'(mq.pop_front());
            m_pkt = (m_pkt + 1 > CNT_MAX) ? CNT_MAX : m_pkt + 1;
        end
        if (!bus.handshake_complete_in) begin
            m_drop = m_drop + $countones(bus.rxpkt_vld_in);
            if (m_drop > CNT_MAX) m_drop = CNT_MAX;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (er[i]) begin
                    mq.push_back('{i, bus.rxpkt_data_in[i]});
                    m_rr = (i + 1) % NCH;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_vld", 80'(bus.pkt_vld_out), 80'(0));
        check("rst_data", 80'(bus.pkt_data_out), 80'(0));
        check("rst_chan", 80'(bus.pkt_chan_out), 80'(0));
        check("rst_pkt_cnt", 80'(bus.pkt_cnt_out), 80'(0));
        check("rst_drop_cnt", 80'(bus.drop_cnt_out), 80'(0));
        check("rst_rdy", 80'(bus.rxpkt_rdy_out), 80'(0));
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        m_rr = 0;
        m_pkt = 0;
        m_drop = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.rxpkt_data_in = '0;
        bus.rxpkt_vld_in = '0;
        bus.handshake_complete_in = 1'b1;
        bus.pkt_rdy_in = 1'b0;
        @(negedge clk);

        // Reset with every input valid: no ready may leak through.
        bus.rxpkt_vld_in = '1;
        do_reset();
        bus.rxpkt_vld_in = '0;

        // Single channel, back-to-back.
        bus.pkt_rdy_in = 1'b1;
        bus.rxpkt_vld_in = 8'h08;
        bus.rxpkt_data_in[3] = 72'hA1;
        cycle();
        bus.rxpkt_data_in[3] = 72'hA2;
        cycle();
        bus.rxpkt_vld_in = '0;
        cycle();
        cycle();
        check("single_pkt_cnt", 80'(bus.pkt_cnt_out), 80'(2));

        // All channels valid from pointer 0.
        do_reset();
        bus.rxpkt_vld_in = '1;
        for (int c = 0; c < 9; c++) begin
            rnd_data();
            cycle();
        end
        bus.rxpkt_vld_in = '0;
        cycle();
        cycle();

        // Backpressure fills both entries, then drains in order.
        do_reset();
        bus.pkt_rdy_in = 1'b0;
        bus.rxpkt_vld_in = 8'h21;
        rnd_data();
        cycle();
        cycle();
        check("bp_full_rdy", 80'(bus.rxpkt_rdy_out), 80'(0));
        cycle();
        cycle();
        bus.pkt_rdy_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rnd_data();
            cycle();
        end
        bus.rxpkt_vld_in = '0;
        for (int c = 0; c < 3; c++) cycle();

        // Flush with one packet buffered.
        do_reset();
        bus.pkt_rdy_in = 1'b0;
        bus.rxpkt_vld_in = 8'h10;
        rnd_data();
        cycle();
        bus.handshake_complete_in = 1'b0;
        bus.rxpkt_vld_in = 8'h46;
        bus.pkt_rdy_in = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        bus.rxpkt_vld_in = '0;
        bus.handshake_complete_in = 1'b1;
        cycle();
        check("flush_drop_cnt", 80'(bus.drop_cnt_out), 80'(12));
        check("flush_pkt_cnt", 80'(bus.pkt_cnt_out), 80'(1));

        // Counter saturation.
        do_reset();
        bus.rxpkt_vld_in = '1;
        for (int c = 0; c < 22; c++) begin
            rnd_data();
            cycle();
        end
        bus.rxpkt_vld_in = '0;
        cycle();
        cycle();
        check("sat_pkt_cnt", 80'(bus.pkt_cnt_out), 80'(CNT_MAX));
        bus.handshake_complete_in = 1'b0;
        bus.rxpkt_vld_in = '1;
        for (int c = 0; c < 3; c++) cycle();
        bus.rxpkt_vld_in = '0;
        bus.handshake_complete_in = 1'b1;
        cycle();
        check("sat_drop_cnt", 80'(bus.drop_cnt_out), 80'(CNT_MAX));

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.rxpkt_vld_in = NCH'($urandom());
            bus.handshake_complete_in = ($urandom_range(0, 7) != 0);
            bus.pkt_rdy_in = 1'($urandom_range(0, 1));
            rnd_data();
            cycle();
        end
        bus.handshake_complete_in = 1'b1;

        // Async reset with both entries occupied.
        do_reset();
        bus.pkt_rdy_in = 1'b0;
        bus.rxpkt_vld_in = 8'h21;
        rnd_data();
        cycle();
        cycle();
        check("pre_rst_vld", 80'(bus.pkt_vld_out), 80'(1));
        do_reset();
        bus.pkt_rdy_in = 1'b1;
        bus.rxpkt_vld_in = 8'h01;
        rnd_data();
        cycle();
        bus.rxpkt_vld_in = '0;
        check("post_rst_latency", 80'(bus.pkt_vld_out), 80'(1));
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
